// File: rtl/mmio_io_pkg.sv
// Shared constants for the MMIO I/O responder: register map, window geometry and
// the seven-segment decode table.
package mmio_io_pkg;

  localparam int unsigned WindowBytes = 32;
  localparam int unsigned WinBits     = $clog2(WindowBytes);

  // Word offsets within the window; 0x18 and 0x1C are reserved.
  localparam logic [4:0] OffSw    = 5'h00;
  localparam logic [4:0] OffLed   = 5'h04;
  localparam logic [4:0] OffSeg1  = 5'h08;
  localparam logic [4:0] OffSeg2  = 5'h0C;
  localparam logic [4:0] OffTimer = 5'h10;
  localparam logic [4:0] OffSwchg = 5'h14;

  // Segment patterns {g,f,e,d,c,b,a}, active-high; index 15 is the leftmost entry.
  localparam logic [15:0][6:0] SegTable = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] hex_to_seg(logic [3:0] digit);
    return SegTable[digit];
  endfunction

endpackage

// File: rtl/mmio_io_responder_if.sv
// CPU-side load/store bus seen by the MMIO I/O responder.
interface mmio_io_responder_if;

  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        io_sel;

  modport master (
    output MemWrite, DataAdr, WriteData,
    input  ReadData, io_sel
  );

  modport slave (
    input  MemWrite, DataAdr, WriteData,
    output ReadData, io_sel
  );

endinterface

// File: rtl/switch_debouncer.sv
// Two-flop synchronizer plus stability counter for the board switches; the debounced
// value follows the synced value once it has held steady for DEBOUNCE_CYCLES cycles.
module switch_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned Width           = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] switches,
  output logic [Width-1:0] debounced,
  output logic             changed
);

  logic [Width-1:0] sync1_q, sync2_q, deb_q;
  logic [7:0]       cnt_q;
  logic             stable;
  logic             hit;

  // sync1 != sync2 means the synced value moves on this edge, which restarts the count.
  assign stable = (sync1_q == sync2_q) && (sync2_q != deb_q);
  assign hit    = stable && (({1'b0, cnt_q} + 9'd1) == 9'(DEBOUNCE_CYCLES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      deb_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= switches;
      sync2_q <= sync1_q;
      if (!stable || hit) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
      if (hit) begin
        deb_q <= sync2_q;
      end
    end
  end

  assign debounced = deb_q;
  assign changed   = hit;

endmodule

// File: rtl/mmio_io_responder.sv
// Memory-mapped I/O block: switches, LEDs, two hex digits, a free-running timer and a
// sticky switch-change flag, all in a 32-byte window with zero-latency reads.
module mmio_io_responder
  import mmio_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h00001000,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  mmio_io_responder_if.slave        bus,
  input  logic [3:0]                switches,
  output logic [3:0]                leds,
  output logic [6:0]                seg1,
  output logic [6:0]                seg2
);

  logic [4:0]  reg_off;
  logic        wr_en;
  logic        unused_adr_lsb;
  logic [3:0]  sw_deb;
  logic        sw_changed;
  logic [3:0]  led_q, dig1_q, dig2_q;
  logic [31:0] timer_q;
  logic        swchg_q;
  logic [31:0] read_data;

  // Byte lanes are not decoded; every access is treated as a full word.
  assign reg_off        = {bus.DataAdr[4:2], 2'b00};
  assign unused_adr_lsb = ^bus.DataAdr[1:0];
  assign bus.io_sel     = (bus.DataAdr[31:WinBits] == BASE_ADDR[31:WinBits]);
  assign wr_en          = bus.MemWrite & bus.io_sel;

  switch_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .Width           (4)
  ) u_switch_debouncer (
    .clk       (clk),
    .reset     (reset),
    .switches  (switches),
    .debounced (sw_deb),
    .changed   (sw_changed)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q  <= '0;
      dig1_q <= '0;
      dig2_q <= '0;
    end else if (wr_en) begin
      case (reg_off)
        OffLed:  led_q  <= bus.WriteData[3:0];
        OffSeg1: dig1_q <= bus.WriteData[3:0];
        OffSeg2: dig2_q <= bus.WriteData[3:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer_q <= '0;
    end else if (wr_en && (reg_off == OffTimer)) begin
      timer_q <= bus.WriteData;
    end else begin
      timer_q <= timer_q + 32'd1;
    end
  end

  // A new debounced change outranks a software clear on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      swchg_q <= 1'b0;
    end else if (sw_changed) begin
      swchg_q <= 1'b1;
    end else if (wr_en && (reg_off == OffSwchg) && bus.WriteData[0]) begin
      swchg_q <= 1'b0;
    end
  end

  always_comb begin
    read_data = '0;
    if (bus.io_sel) begin
      case (reg_off)
        OffSw:    read_data = {28'b0, sw_deb};
        OffLed:   read_data = {28'b0, led_q};
        OffSeg1:  read_data = {28'b0, dig1_q};
        OffSeg2:  read_data = {28'b0, dig2_q};
        OffTimer: read_data = timer_q;
        OffSwchg: read_data = {31'b0, swchg_q};
        default:  read_data = '0;
      endcase
    end
  end

  assign bus.ReadData = read_data;
  assign leds         = led_q;
  assign seg1         = hex_to_seg(dig1_q);
  assign seg2         = hex_to_seg(dig2_q);

endmodule

// File: tb/tb_mmio_io_responder.sv
// Self-checking bench for mmio_io_responder: directed scenarios plus random traffic
// compared against a history-based behavioural model.
module tb_mmio_io_responder;

  localparam logic [31:0] BASE = 32'h00001000;
  localparam int          DB   = 4;

  logic       clk      = 1'b0;
  logic       reset    = 1'b1;
  logic [3:0] switches = 4'h0;
  logic [3:0] leds;
  logic [6:0] seg1, seg2;

  int total = 0;
  int bad   = 0;

  mmio_io_responder_if bus ();

  mmio_io_responder #(
    .BASE_ADDR       (BASE),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .switches (switches),
    .leds     (leds),
    .seg1     (seg1),
    .seg2     (seg2)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                              7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Behavioural model state.
  logic [3:0]  m_led, m_d1, m_d2, m_deb, m_sync1;
  logic [31:0] m_timer;
  logic        m_flag;
  logic [3:0]  m_hist[$];

  function automatic logic in_window(input logic [31:0] a);
    return a[31:5] == BASE[31:5];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (!in_window(a)) return 32'h0;
    case (a[4:2])
      3'd0:    return {28'b0, m_deb};
      3'd1:    return {28'b0, m_led};
      3'd2:    return {28'b0, m_d1};
      3'd3:    return {28'b0, m_d2};
      3'd4:    return m_timer;
      3'd5:    return {31'b0, m_flag};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_led = 0; m_d1 = 0; m_d2 = 0; m_deb = 0; m_sync1 = 0;
    m_timer = 0; m_flag = 0;
    m_hist.delete();
  endtask

  // One clock edge with the given bus transfer; the model advances in step.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] wd);
    logic [3:0] s2;
    logic       chg, hitw;
    bus.MemWrite  = we;
    bus.DataAdr   = a;
    bus.WriteData = wd;
    @(posedge clk);
    s2      = m_sync1;
    m_sync1 = switches;
    m_hist.push_back(s2);
    if (m_hist.size() > DB + 1) void'(m_hist.pop_front());
    // Debounced value follows once the synced history holds one value for D+1 samples.
    chg = 1'b0;
    if (m_hist.size() == DB + 1 && m_hist[0] != m_deb) begin
      chg = 1'b1;
      foreach (m_hist[i]) if (m_hist[i] != m_hist[0]) chg = 1'b0;
    end
    hitw = we && in_window(a);
    if (hitw) begin
      case (a[4:2])
        3'd1:    m_led = wd[3:0];
        3'd2:    m_d1  = wd[3:0];
        3'd3:    m_d2  = wd[3:0];
        default: ;
      endcase
    end
    if (hitw && a[4:2] == 3'd4) m_timer = wd;
    else m_timer = m_timer + 32'd1;
    if (chg) begin
      m_deb  = m_hist[0];
      m_flag = 1'b1;
    end else if (hitw && a[4:2] == 3'd5 && wd[0]) begin
      m_flag = 1'b0;
    end
    #1;
    bus.MemWrite = 1'b0;
  endtask

  task automatic peek(input logic [31:0] a);
    bus.MemWrite = 1'b0;
    bus.DataAdr  = a;
    #1;
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    model_reset();
    #1;
    total++; if (leds !== 4'h0) begin bad++; $display("FAIL rst_leds: got %h want 0", leds); end
    total++; if (seg1 !== 7'h3F) begin bad++; $display("FAIL rst_seg1: got %h want 3f", seg1); end
    total++; if (seg2 !== 7'h3F) begin bad++; $display("FAIL rst_seg2: got %h want 3f", seg2); end
    @(posedge clk); @(posedge clk); #2 reset = 1'b1;
    peek(BASE + 32'h10);
    total++; if (bus.ReadData !== 32'd0) begin bad++; $display("FAIL rst_timer0: got %h want 0", bus.ReadData); end
    peek(BASE + 32'h14);
    total++; if (bus.ReadData !== 32'd0) begin bad++; $display("FAIL rst_swchg: got %h want 0", bus.ReadData); end
    step(1'b0, BASE, 32'h0);
    peek(BASE + 32'h10);
    total++; if (bus.ReadData !== 32'd1) begin bad++; $display("FAIL rst_timer1: got %h want 1", bus.ReadData); end
  endtask

  task automatic test_led_seg();
    logic [31:0] exp_rd [3] = '{32'd9, 32'd10, 32'd5};
    step(1'b1, BASE + 32'h04, 32'h9);
    total++; if (leds !== 4'b1001) begin bad++; $display("FAIL led_write: got %b want 1001", leds); end
    step(1'b1, BASE + 32'h08, 32'hFFFF_FFFA);
    step(1'b1, BASE + 32'h0C, 32'h5);
    total++; if (seg1 !== 7'h77) begin bad++; $display("FAIL seg1_A: got %h want 77", seg1); end
    total++; if (seg2 !== 7'h6D) begin bad++; $display("FAIL seg2_5: got %h want 6d", seg2); end
    for (int i = 0; i < 3; i++) begin
      peek(BASE + 32'h04 + 32'(4 * i));
      total++;
      if (bus.ReadData !== exp_rd[i]) begin
        bad++; $display("FAIL readback%0d: got %h want %h", i, bus.ReadData, exp_rd[i]);
      end
    end
  endtask

  task automatic test_switch_debounce();
    logic [3:0] exp;
    switches = 4'b1010;
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, BASE, 32'h0);
      peek(BASE);
      exp = (k <= 2 + DB - 1) ? 4'b0000 : 4'b1010;
      total++;
      if (bus.ReadData !== {28'b0, exp}) begin
        bad++; $display("FAIL sw_step c%0d: got %h want %h", k, bus.ReadData, exp);
      end
    end
    peek(BASE + 32'h14);
    total++; if (bus.ReadData !== 32'd1) begin bad++; $display("FAIL swchg_set: got %h want 1", bus.ReadData); end
    switches = 4'b1111;
    step(1'b0, BASE, 32'h0);
    step(1'b0, BASE, 32'h0);
    switches = 4'b1010;
    for (int k = 0; k < 10; k++) begin
      step(1'b0, BASE, 32'h0);
      peek(BASE);
      total++;
      if (bus.ReadData !== 32'hA) begin
        bad++; $display("FAIL glitch c%0d: got %h want a", k, bus.ReadData);
      end
    end
    peek(BASE + 32'h14);
    total++; if (bus.ReadData !== 32'd1) begin bad++; $display("FAIL glitch_swchg: got %h want 1", bus.ReadData); end
  endtask

  task automatic test_timer_wrap();
    logic [31:0] exp [3] = '{32'hFFFF_FFFF, 32'h0, 32'h1};
    step(1'b1, BASE + 32'h10, 32'hFFFF_FFFE);
    peek(BASE + 32'h10);
    total++; if (bus.ReadData !== 32'hFFFF_FFFE) begin bad++; $display("FAIL timer_load: got %h want fffffffe", bus.ReadData); end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, BASE, 32'h0);
      peek(BASE + 32'h10);
      total++;
      if (bus.ReadData !== exp[i]) begin
        bad++; $display("FAIL timer_wrap%0d: got %h want %h", i, bus.ReadData, exp[i]);
      end
    end
  endtask

  task automatic test_swchg_same_edge();
    switches = 4'b0101;
    for (int k = 1; k < 2 + DB; k++) step(1'b0, BASE, 32'h0);
    step(1'b1, BASE + 32'h14, 32'h1);
    peek(BASE);
    total++; if (bus.ReadData !== 32'h5) begin bad++; $display("FAIL same_edge_sw: got %h want 5", bus.ReadData); end
    peek(BASE + 32'h14);
    total++; if (bus.ReadData !== 32'd1) begin bad++; $display("FAIL same_edge_flag: got %h want 1", bus.ReadData); end
    step(1'b1, BASE + 32'h14, 32'h1);
    peek(BASE + 32'h14);
    total++; if (bus.ReadData !== 32'd0) begin bad++; $display("FAIL swchg_clear: got %h want 0", bus.ReadData); end
  endtask

  task automatic test_outside_window();
    logic [31:0] addrs [5] = '{32'h60, BASE + 32'h18, BASE + 32'h1C, BASE - 32'h4, BASE + 32'h20};
    logic        sel   [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      bus.MemWrite = 1'b1; bus.DataAdr = addrs[i]; bus.WriteData = 32'hFFFF_FFFF;
      #1;
      total++;
      if (bus.io_sel !== sel[i] || bus.ReadData !== 32'h0) begin
        bad++; $display("FAIL outside%0d: io_sel %b rd %h want io_sel %b rd 0",
                        i, bus.io_sel, bus.ReadData, sel[i]);
      end
      step(1'b1, addrs[i], 32'hFFFF_FFFF);
    end
    step(1'b1, BASE, 32'hF);
    for (int r = 0; r < 6; r++) begin
      peek(BASE + 32'(4 * r));
      total++;
      if (bus.ReadData !== model_read(BASE + 32'(4 * r))) begin
        bad++; $display("FAIL no_side_effect r%0d: got %h want %h", r, bus.ReadData,
                        model_read(BASE + 32'(4 * r)));
      end
    end
    total++; if (leds !== 4'b1001) begin bad++; $display("FAIL outside_leds: got %b want 1001", leds); end
  endtask

  task automatic test_reset_abort();
    step(1'b1, BASE + 32'h04, 32'hF);
    switches = 4'b0011;
    for (int k = 0; k < 3; k++) step(1'b0, BASE, 32'h0);
    #2 reset = 1'b0;
    model_reset();
    #1;
    total++; if (leds !== 4'h0) begin bad++; $display("FAIL abort_leds: got %h want 0", leds); end
    @(posedge clk); @(posedge clk); #2 reset = 1'b1;
    peek(BASE + 32'h14);
    total++; if (bus.ReadData !== 32'd0) begin bad++; $display("FAIL abort_flag: got %h want 0", bus.ReadData); end
    for (int k = 1; k <= 7; k++) begin
      step(1'b0, BASE, 32'h0);
      peek(BASE + 32'h14);
      total++;
      if (bus.ReadData !== ((k >= 2 + DB) ? 32'd1 : 32'd0)) begin
        bad++; $display("FAIL post_rst_flag c%0d: got %h", k, bus.ReadData);
      end
      peek(BASE);
      total++;
      if (bus.ReadData !== ((k >= 2 + DB) ? 32'h3 : 32'h0)) begin
        bad++; $display("FAIL post_rst_sw c%0d: got %h", k, bus.ReadData);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a, wd;
    logic        we;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 5) == 0) switches = 4'($urandom);
      we = 1'($urandom);
      wd = $urandom;
      if ($urandom_range(0, 4) != 0) a = BASE + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      else a = $urandom;
      bus.MemWrite = we; bus.DataAdr = a; bus.WriteData = wd;
      #1;
      total++;
      if (bus.io_sel !== in_window(a) || bus.ReadData !== model_read(a)) begin
        bad++; $display("FAIL rand_read n%0d a=%h: io_sel %b rd %h want io_sel %b rd %h",
                        n, a, bus.io_sel, bus.ReadData, in_window(a), model_read(a));
      end
      step(we, a, wd);
      total++;
      if (leds !== m_led || seg1 !== seg_ref[m_d1] || seg2 !== seg_ref[m_d2]) begin
        bad++; $display("FAIL rand_out n%0d: leds %h seg %h/%h want %h %h/%h",
                        n, leds, seg1, seg2, m_led, seg_ref[m_d1], seg_ref[m_d2]);
      end
    end
  endtask

  initial begin
    bus.MemWrite  = 1'b0;
    bus.DataAdr   = 32'h0;
    bus.WriteData = 32'h0;
    model_reset();
    test_reset();
    test_led_seg();
    test_switch_debounce();
    test_timer_wrap();
    test_swchg_same_edge();
    test_outside_window();
    test_reset_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
